// File: rtl/opb_insel_sequencer.sv
// rtl/opb_insel_sequencer.sv - OPB slave that steps a table of input-select words on fabric sync pulses
module opb_insel_sequencer #(
   parameter logic [31:0] C_BASEADDR   = 32'h01014000,
   parameter logic [31:0] C_HIGHADDR   = 32'h010140FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter string       C_FAMILY     = "virtex5"
) (
   input  logic                    OPB_Clk,
   input  logic                    OPB_Rst,
   input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
   input  logic [0:3]              OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
   input  logic                    OPB_RNW,
   input  logic                    OPB_select,
   input  logic                    OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
   output logic                    Sl_xferAck,
   output logic                    Sl_errAck,
   output logic                    Sl_retry,
   output logic                    Sl_toutSup,
   input  logic                    sync_in,
   output logic [31:0]             insel_data,
   output logic                    insel_valid,
   output logic [2:0]              insel_index
);

   localparam string lp_unused_family = C_FAMILY;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;

   logic [1:0]  r_state;
   logic        r_run;
   logic [2:0]  r_last_idx;
   logic [15:0] r_dwell;
   logic [15:0] r_dwell_cnt;
   logic [15:0] r_wrap_cnt;
   logic [2:0]  r_index;
   logic [31:0] r_data;
   logic        r_valid;
   logic        r_ack;
   logic [31:0] r_rdata;
   logic [31:0] r_table [0:7];

   logic [31:0] w_addr;
   logic [31:0] w_wdata;
   logic [3:0]  w_be;
   logic [31:0] w_mask;
   logic [5:0]  w_word;
   logic        w_hit;
   logic        w_wr;
   logic [31:0] w_rd;
   logic [31:0] w_merged;
   logic        w_run_nxt;
   logic [2:0]  w_next_idx;
   logic        w_unused_seqaddr;

   // OPB is big-endian numbered, so a straight assignment puts bit 0 at value bit 31
   assign w_addr   = OPB_ABus;
   assign w_wdata  = OPB_DBus;
   assign w_be     = OPB_BE;
   assign w_mask   = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
   assign w_word   = w_addr[7:2];
   assign w_hit    = OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR) && !r_ack;
   assign w_wr     = w_hit && !OPB_RNW;
   assign w_merged = (w_rd & ~w_mask) | (w_wdata & w_mask);
   assign w_run_nxt  = (w_wr && w_word == 6'h00 && w_be[0]) ? w_wdata[0] : r_run;
   assign w_next_idx = (r_index >= r_last_idx) ? 3'd0 : r_index + 3'd1;
   assign w_unused_seqaddr = OPB_seqAddr;

   always_comb begin
      w_rd = 32'h0;
      if (w_word == 6'h00)
         w_rd = {21'h0, r_last_idx, 7'h0, r_run};
      else if (w_word == 6'h01)
         w_rd = {r_wrap_cnt, 10'h0, r_state, 1'b0, r_index};
      else if (w_word == 6'h02)
         w_rd = {16'h0, r_dwell};
      else if (w_word[5:3] == 3'b010)
         w_rd = r_table[w_word[2:0]];
   end

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         r_state     <= ST_IDLE;
         r_run       <= 1'b0;
         r_last_idx  <= 3'd0;
         r_dwell     <= 16'h0;
         r_dwell_cnt <= 16'h0;
         r_wrap_cnt  <= 16'h0;
         r_index     <= 3'd0;
         r_data      <= 32'h0;
         r_valid     <= 1'b0;
         r_ack       <= 1'b0;
         r_rdata     <= 32'h0;
         for (int i = 0; i < 8; i++) r_table[i] <= 32'h0;
      end else begin
         r_ack   <= w_hit;
         r_rdata <= (w_hit && OPB_RNW) ? w_rd : 32'h0;
         r_valid <= 1'b0;

         // STATUS and unmapped words fall through: their writes are dropped
         if (w_wr && w_word == 6'h00) begin
            r_run      <= w_run_nxt;
            r_last_idx <= w_merged[10:8];
         end
         if (w_wr && w_word == 6'h02)
            r_dwell <= w_merged[15:0];
         if (w_wr && w_word[5:3] == 3'b010)
            r_table[w_word[2:0]] <= w_merged;

         // A run change decided this cycle takes priority over a coincident sync
         case (r_state)
            ST_IDLE: begin
               if (w_run_nxt) begin
                  r_state    <= ST_ARMED;
                  r_wrap_cnt <= 16'h0;
               end
            end
            ST_ARMED: begin
               if (!w_run_nxt) begin
                  r_state <= ST_IDLE;
               end else if (sync_in) begin
                  r_data      <= r_table[0];
                  r_index     <= 3'd0;
                  r_dwell_cnt <= r_dwell;
                  r_valid     <= 1'b1;
                  r_state     <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (!w_run_nxt) begin
                  r_state <= ST_IDLE;
               end else if (sync_in) begin
                  if (r_dwell_cnt != 16'h0) begin
                     r_dwell_cnt <= r_dwell_cnt - 16'h1;
                  end else begin
                     r_data      <= r_table[w_next_idx];
                     r_index     <= w_next_idx;
                     r_dwell_cnt <= r_dwell;
                     r_valid     <= 1'b1;
                     if (w_next_idx == 3'd0) r_wrap_cnt <= r_wrap_cnt + 16'h1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign Sl_DBus     = r_rdata;
   assign Sl_xferAck  = r_ack;
   assign Sl_errAck   = 1'b0;
   assign Sl_retry    = 1'b0;
   assign Sl_toutSup  = 1'b0;
   assign insel_data  = r_data;
   assign insel_valid = r_valid;
   assign insel_index = r_index;

endmodule

// File: tb/tb_opb_insel_sequencer.sv
// tb/tb_opb_insel_sequencer.sv - bench for opb_insel_sequencer against a transaction-level model
module tb_opb_insel_sequencer;
   localparam logic [31:0] BASE = 32'h01014000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic [0:31] abus = '0;
   logic [0:3]  be_p = '0;
   logic [0:31] dbus = '0;
   logic        rnw = 1'b0, sel = 1'b0, seqa = 1'b0, sync_in = 1'b0;
   logic [0:31] sl_dbus;
   logic        ack, erra, retry, tout;
   logic [31:0] insel_data;
   logic        insel_valid;
   logic [2:0]  insel_index;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] m_table [8];
   logic [15:0] m_dwell, m_dcnt, m_wrap;
   logic [2:0]  m_last, m_index;
   logic        m_run;
   int          m_state;
   logic [31:0] m_data;

   opb_insel_sequencer dut (
      .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be_p), .OPB_DBus(dbus),
      .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seqa), .Sl_DBus(sl_dbus),
      .Sl_xferAck(ack), .Sl_errAck(erra), .Sl_retry(retry), .Sl_toutSup(tout),
      .sync_in(sync_in), .insel_data(insel_data), .insel_valid(insel_valid),
      .insel_index(insel_index)
   );

   task automatic m_clear();
      for (int i = 0; i < 8; i++) m_table[i] = 32'h0;
      m_dwell = 0; m_dcnt = 0; m_wrap = 0; m_last = 0; m_index = 0;
      m_run = 0; m_state = 0; m_data = 0;
   endtask

   function automatic logic [31:0] m_read(input logic [7:0] off);
      if (off == 8'h00) return {21'h0, m_last, 7'h0, m_run};
      if (off == 8'h04) return {m_wrap, 10'h0, m_state[1:0], 1'b0, m_index};
      if (off == 8'h08) return {16'h0, m_dwell};
      if (off >= 8'h40 && off <= 8'h5C) return m_table[off[4:2]];
      return 32'h0;
   endfunction

   // state numbering 0 idle, 1 armed, 2 running; one call per bus hit and/or sync
   task automatic m_apply(input logic [7:0] off, input logic [31:0] d, input logic [3:0] be,
                          input logic wr, input logic sy, output logic ev);
      logic [31:0] msk;
      logic        nrun;
      int          nxt;
      ev   = 1'b0;
      msk  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      nrun = (wr && off == 8'h00 && be[0]) ? d[0] : m_run;
      if (m_state == 0) begin
         if (nrun) begin m_state = 1; m_wrap = 0; end
      end else if (!nrun) begin
         m_state = 0;
      end else if (sy && m_state == 1) begin
         m_data = m_table[0]; m_index = 0; m_dcnt = m_dwell; m_state = 2; ev = 1'b1;
      end else if (sy) begin
         if (m_dcnt > 0) m_dcnt = m_dcnt - 1;
         else begin
            nxt = (int'(m_index) >= int'(m_last)) ? 0 : int'(m_index) + 1;
            if (nxt == 0) m_wrap = m_wrap + 1;
            m_index = 3'(nxt); m_data = m_table[nxt]; m_dcnt = m_dwell; ev = 1'b1;
         end
      end
      if (wr) begin
         if (off == 8'h00) begin m_run = nrun; if (be[1]) m_last = d[10:8]; end
         if (off == 8'h08) m_dwell = (m_dwell & ~msk[15:0]) | (d[15:0] & msk[15:0]);
         if (off >= 8'h40 && off <= 8'h5C)
            m_table[off[4:2]] = (m_table[off[4:2]] & ~msk) | (d & msk);
      end
   endtask

   task automatic bus(input logic rnw_i, input logic [7:0] off, input logic [31:0] d,
                      input logic [3:0] be, input logic sy, output logic [2:0] a,
                      output logic [31:0] rd, output logic [31:0] exp_rd,
                      output logic v, output logic exp_v);
      @(negedge clk);
      rnw = rnw_i; abus = BASE + 32'(off); dbus = rnw_i ? 32'h0 : d; be_p = be;
      sel = 1'b1; sync_in = sy;
      a[2] = ack;
      exp_rd = rnw_i ? m_read(off) : 32'h0;
      m_apply(off, d, be, !rnw_i, sy, exp_v);
      @(posedge clk); #1;
      a[1] = ack; rd = sl_dbus; v = insel_valid;
      @(negedge clk);
      sel = 1'b0; sync_in = 1'b0; rnw = 1'b0;
      @(posedge clk); #1;
      a[0] = ack;
   endtask

   task automatic pulse(output logic v, output logic exp_v, output logic v2);
      @(negedge clk);
      sync_in = 1'b1;
      m_apply(8'hFF, 32'h0, 4'h0, 1'b0, 1'b1, exp_v);
      @(posedge clk); #1 v = insel_valid;
      @(negedge clk);
      sync_in = 1'b0;
      @(posedge clk); #1 v2 = insel_valid;
   endtask

   task automatic do_reset(input logic sy);
      @(negedge clk);
      rst = 1'b1; sync_in = sy; sel = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      rst = 1'b0; sync_in = 1'b0;
      m_clear();
   endtask

   task automatic test_reset();
      logic [2:0] a; logic [31:0] rd, er; logic v, ev;
      logic [7:0] offs [4];
      offs = '{8'h00, 8'h04, 8'h08, 8'h40};
      do_reset(1'b0);
      n_vec++;
      if (insel_data !== 32'h0 || insel_index !== 3'd0 || insel_valid !== 1'b0 ||
          ack !== 1'b0 || sl_dbus !== 32'h0) begin
         n_err++;
         $display("FAIL reset_outputs: data=%h idx=%0d valid=%b ack=%b dbus=%h, expected all 0",
                  insel_data, insel_index, insel_valid, ack, sl_dbus);
      end
      for (int i = 0; i < 4; i++) begin
         bus(1'b1, offs[i], 32'h0, 4'hF, 1'b0, a, rd, er, v, ev);
         n_vec++;
         if (a !== 3'b010 || rd !== 32'h0) begin
            n_err++;
            $display("FAIL reset_read_%h: ack=%b rd=%h, expected ack=010 rd=00000000", offs[i], a, rd);
         end
      end
   endtask

   task automatic test_sequence();
      logic [2:0] a; logic [31:0] rd, er; logic v, ev, v2; int pulses;
      for (int k = 0; k < 4; k++)
         bus(1'b0, 8'h40 + 8'(4 * k), 32'hA0 + 32'(k), 4'hF, 1'b0, a, rd, er, v, ev);
      bus(1'b0, 8'h08, 32'h0, 4'hF, 1'b0, a, rd, er, v, ev);
      bus(1'b0, 8'h00, 32'h301, 4'hF, 1'b0, a, rd, er, v, ev);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         pulse(v, ev, v2);
         if (v === 1'b1) pulses++;
         n_vec++;
         if (v !== 1'b1 || v2 !== 1'b0 || insel_data !== 32'hA0 + 32'(i % 4) || insel_index !== 3'(i % 4)) begin
            n_err++;
            $display("FAIL seq_step%0d: valid=%b,%b data=%h idx=%0d, expected valid=1,0 data=%h idx=%0d",
                     i, v, v2, insel_data, insel_index, 32'hA0 + 32'(i % 4), i % 4);
         end
      end
      n_vec++;
      if (pulses != 6) begin n_err++; $display("FAIL seq_pulses: got %0d, expected 6", pulses); end
      bus(1'b1, 8'h04, 32'h0, 4'hF, 1'b0, a, rd, er, v, ev);
      n_vec++;
      if (a !== 3'b010 || rd !== 32'h00010021) begin
         n_err++; $display("FAIL seq_status: ack=%b rd=%h, expected ack=010 rd=00010021", a, rd);
      end
   endtask

   task automatic test_back_to_back();
      logic a4 [4]; logic [31:0] d4 [4]; logic o1, o2;
      @(negedge clk);
      sel = 1'b1; rnw = 1'b1; abus = BASE; be_p = 4'hF;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         a4[i] = ack; d4[i] = sl_dbus;
      end
      @(negedge clk);
      abus = BASE + 32'h100;
      @(posedge clk); #1 o1 = ack;
      @(negedge clk);
      abus = BASE - 32'h4;
      @(posedge clk); #1 o2 = ack;
      @(negedge clk);
      sel = 1'b0; rnw = 1'b0;
      n_vec++;
      if (a4[0] !== 1'b1 || a4[1] !== 1'b0 || a4[2] !== 1'b1 || a4[3] !== 1'b0) begin
         n_err++; $display("FAIL b2b_ack: %b%b%b%b, expected 1010", a4[0], a4[1], a4[2], a4[3]);
      end
      n_vec++;
      if (d4[0] !== 32'h301 || d4[1] !== 32'h0 || d4[2] !== 32'h301) begin
         n_err++; $display("FAIL b2b_data: %h %h %h, expected 00000301 00000000 00000301", d4[0], d4[1], d4[2]);
      end
      n_vec++;
      if (o1 !== 1'b0 || o2 !== 1'b0) begin
         n_err++; $display("FAIL out_of_window_ack: %b %b, expected 0 0", o1, o2);
      end
   endtask

   task automatic test_dwell();
      logic [2:0] a; logic [31:0] rd, er; logic v, ev, v2;
      bus(1'b0, 8'h00, 32'h0, 4'hF, 1'b0, a, rd, er, v, ev);
      bus(1'b0, 8'h08, 32'h2, 4'hF, 1'b0, a, rd, er, v, ev);
      bus(1'b0, 8'h00, 32'h101, 4'hF, 1'b0, a, rd, er, v, ev);
      for (int i = 0; i < 7; i++) begin
         pulse(v, ev, v2);
         n_vec++;
         if (v !== 1'((i % 3) == 0) || insel_data !== 32'hA0 + 32'((i / 3) % 2)) begin
            n_err++;
            $display("FAIL dwell_sync%0d: valid=%b data=%h, expected valid=%b data=%h",
                     i + 1, v, insel_data, (i % 3) == 0, 32'hA0 + 32'((i / 3) % 2));
         end
      end
   endtask

   task automatic test_clear_on_sync();
      logic [2:0] a; logic [31:0] rd, er; logic v, ev;
      bus(1'b0, 8'h00, 32'h100, 4'hF, 1'b1, a, rd, er, v, ev);
      n_vec++;
      if (v !== 1'b0 || insel_data !== 32'hA0 || insel_index !== 3'd0) begin
         n_err++; $display("FAIL clear_on_sync: valid=%b data=%h idx=%0d, expected 0 000000a0 0", v, insel_data, insel_index);
      end
      bus(1'b1, 8'h04, 32'h0, 4'hF, 1'b0, a, rd, er, v, ev);
      n_vec++;
      if (rd !== 32'h00010000) begin
         n_err++; $display("FAIL clear_status: rd=%h, expected 00010000", rd);
      end
   endtask

   task automatic test_set_on_sync();
      logic [2:0] a; logic [31:0] rd, er; logic v, ev, v2;
      bus(1'b0, 8'h00, 32'h101, 4'hF, 1'b1, a, rd, er, v, ev);
      bus(1'b1, 8'h04, 32'h0, 4'hF, 1'b0, a, rd, er, v, ev);
      n_vec++;
      if (rd !== 32'h00000010 || v !== 1'b0) begin
         n_err++; $display("FAIL set_on_sync_armed: status=%h valid=%b, expected 00000010 0", rd, v);
      end
      pulse(v, ev, v2);
      n_vec++;
      if (v !== 1'b1 || v2 !== 1'b0 || insel_data !== 32'hA0) begin
         n_err++; $display("FAIL set_on_sync_first: valid=%b,%b data=%h, expected 1,0 000000a0", v, v2, insel_data);
      end
   endtask

   task automatic test_shrink_last();
      logic [2:0] a; logic [31:0] rd, er; logic v, ev, v2;
      bus(1'b0, 8'h00, 32'h0, 4'hF, 1'b0, a, rd, er, v, ev);
      bus(1'b0, 8'h08, 32'h0, 4'hF, 1'b0, a, rd, er, v, ev);
      bus(1'b0, 8'h00, 32'h301, 4'hF, 1'b0, a, rd, er, v, ev);
      for (int i = 0; i < 4; i++) pulse(v, ev, v2);
      n_vec++;
      if (insel_index !== 3'd3 || insel_data !== 32'hA3) begin
         n_err++; $display("FAIL shrink_pre: idx=%0d data=%h, expected 3 000000a3", insel_index, insel_data);
      end
      bus(1'b0, 8'h00, 32'h101, 4'hF, 1'b0, a, rd, er, v, ev);
      pulse(v, ev, v2);
      n_vec++;
      if (v !== 1'b1 || insel_index !== 3'd0 || insel_data !== 32'hA0) begin
         n_err++; $display("FAIL shrink_wrap: valid=%b idx=%0d data=%h, expected 1 0 000000a0", v, insel_index, insel_data);
      end
      bus(1'b1, 8'h04, 32'h0, 4'hF, 1'b0, a, rd, er, v, ev);
      n_vec++;
      if (rd !== 32'h00010020) begin
         n_err++; $display("FAIL shrink_status: rd=%h, expected 00010020", rd);
      end
   endtask

   task automatic test_byte_enable();
      logic [2:0] a; logic [31:0] rd, er; logic v, ev;
      bus(1'b0, 8'h40, 32'h11223344, 4'hF, 1'b0, a, rd, er, v, ev);
      bus(1'b0, 8'h40, 32'hFFFFFFFF, 4'b0001, 1'b0, a, rd, er, v, ev);
      bus(1'b1, 8'h40, 32'h0, 4'hF, 1'b0, a, rd, er, v, ev);
      n_vec++;
      if (rd !== 32'h112233FF) begin n_err++; $display("FAIL be_low: rd=%h, expected 112233ff", rd); end
      bus(1'b0, 8'h40, 32'h00AA0000, 4'b0100, 1'b0, a, rd, er, v, ev);
      bus(1'b1, 8'h40, 32'h0, 4'hF, 1'b0, a, rd, er, v, ev);
      n_vec++;
      if (rd !== 32'h11AA33FF) begin n_err++; $display("FAIL be_byte2: rd=%h, expected 11aa33ff", rd); end
      n_vec++;
      if (insel_data !== 32'hA0) begin
         n_err++; $display("FAIL table_write_held: data=%h, expected 000000a0", insel_data);
      end
      bus(1'b0, 8'h04, 32'hFFFFFFFF, 4'hF, 1'b0, a, rd, er, v, ev);
      bus(1'b1, 8'h04, 32'h0, 4'hF, 1'b0, a, rd, er, v, ev);
      n_vec++;
      if (rd !== 32'h00010020) begin n_err++; $display("FAIL status_ro: rd=%h, expected 00010020", rd); end
      bus(1'b0, 8'h80, 32'hDEADBEEF, 4'hF, 1'b0, a, rd, er, v, ev);
      bus(1'b1, 8'h80, 32'h0, 4'hF, 1'b0, a, rd, er, v, ev);
      n_vec++;
      if (a !== 3'b010 || rd !== 32'h0) begin
         n_err++; $display("FAIL unmapped: ack=%b rd=%h, expected 010 00000000", a, rd);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [2:0] a; logic [31:0] rd, er; logic v, ev;
      do_reset(1'b1);
      n_vec++;
      if (insel_valid !== 1'b0 || insel_data !== 32'h0 || insel_index !== 3'd0) begin
         n_err++; $display("FAIL reset_mid_run: valid=%b data=%h idx=%0d, expected 0 0 0", insel_valid, insel_data, insel_index);
      end
      bus(1'b1, 8'h04, 32'h0, 4'hF, 1'b0, a, rd, er, v, ev);
      n_vec++;
      if (rd !== 32'h0) begin n_err++; $display("FAIL reset_mid_status: rd=%h, expected 00000000", rd); end
   endtask

   task automatic test_random();
      logic [2:0] a; logic [31:0] rd, er; logic v, ev, v2;
      logic [7:0] off; int r, k, s;
      logic [7:0] roffs [5];
      roffs = '{8'h00, 8'h04, 8'h08, 8'h40, 8'h0C};
      bus(1'b0, 8'h00, 32'h701, 4'hF, 1'b0, a, rd, er, v, ev);
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 9);
         if (r <= 4) begin
            pulse(v, ev, v2);
            n_vec++;
            if (v !== ev || v2 !== 1'b0 || insel_data !== m_data || insel_index !== m_index) begin
               n_err++;
               $display("FAIL rand_sync%0d: valid=%b,%b data=%h idx=%0d, expected %b,0 %h %0d",
                        n, v, v2, insel_data, insel_index, ev, m_data, m_index);
            end
         end else if (r == 9) begin
            @(negedge clk);
            @(posedge clk); #1;
            n_vec++;
            if (insel_valid !== 1'b0 || insel_data !== m_data) begin
               n_err++; $display("FAIL rand_idle%0d: valid=%b data=%h, expected 0 %h", n, insel_valid, insel_data, m_data);
            end
         end else begin
            k = $urandom_range(0, 7);
            if (r == 5)
               bus(1'b0, 8'h40 + 8'(4 * k), $urandom, 4'($urandom_range(0, 15)), 1'b0, a, rd, er, v, ev);
            else if (r == 6)
               bus(1'b0, 8'h08, 32'($urandom_range(0, 3)), 4'h3, 1'($urandom_range(0, 1)), a, rd, er, v, ev);
            else if (r == 7)
               bus(1'b0, 8'h00, {21'h0, 3'($urandom_range(0, 7)), 7'h0, 1'($urandom_range(0, 4) != 0)},
                   4'hF, 1'($urandom_range(0, 1)), a, rd, er, v, ev);
            else begin
               s = $urandom_range(0, 4);
               off = roffs[s] + ((s == 3) ? 8'(4 * k) : 8'h0);
               bus(1'b1, off, 32'h0, 4'hF, 1'($urandom_range(0, 1)), a, rd, er, v, ev);
            end
            n_vec++;
            if (a !== 3'b010 || rd !== er || v !== ev || insel_data !== m_data || insel_index !== m_index) begin
               n_err++;
               $display("FAIL rand_bus%0d: ack=%b rd=%h valid=%b data=%h idx=%0d, expected 010 %h %b %h %0d",
                        n, a, rd, v, insel_data, insel_index, er, ev, m_data, m_index);
            end
         end
      end
   endtask

   initial begin
      m_clear();
      test_reset();
      test_sequence();
      test_back_to_back();
      test_dwell();
      test_clear_on_sync();
      test_set_on_sync();
      test_shrink_last();
      test_byte_enable();
      test_reset_mid_run();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
